// File: rtl/vc_classifier.sv
// Routes main-FIFO words to two VC FIFOs by a class bit and tracks
// their occupancy to drive hysteretic pause backpressure per VC.
module vc_classifier #(
    parameter int DATA_WIDTH = 6,
    parameter int CLASS_BIT  = 4,
    parameter int DEPTH      = 8,
    parameter int HIGH_TH    = 5,
    parameter int LOW_TH     = 2,
    localparam int OW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop_vc0,
    input  logic                  pop_vc1,
    output logic [DATA_WIDTH-1:0] data_out_vc0,
    output logic [DATA_WIDTH-1:0] data_out_vc1,
    output logic                  push_vc0,
    output logic                  push_vc1,
    output logic                  pause_vc0,
    output logic                  pause_vc1,
    output logic [OW-1:0]         occ_vc0,
    output logic [OW-1:0]         occ_vc1,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    localparam logic [OW-1:0] FULL = OW'(DEPTH);
    localparam logic [OW:0]   HI   = (OW + 1)'(HIGH_TH);
    localparam logic [OW:0]   LO   = (OW + 1)'(LOW_TH);

    state_t                r_state     [2];
    state_t                w_state_nxt [2];
    logic [OW-1:0]         r_occ       [2];
    logic [OW-1:0]         w_occ_nxt   [2];
    logic [OW:0]           w_eff       [2];
    logic [DATA_WIDTH-1:0] r_data      [2];
    logic [1:0]            r_push;
    logic [1:0]            w_route;
    logic [1:0]            w_pop;
    logic [1:0]            w_push;
    logic [1:0]            w_ovf;
    logic [1:0]            w_unf;
    logic                  r_ovf;
    logic                  r_unf;

    // A full VC drops the word unless the consumer frees a slot this cycle.
    always_comb begin
        w_route = {valid_in & data_in[CLASS_BIT],
                   valid_in & ~data_in[CLASS_BIT]};
        w_pop   = {pop_vc1, pop_vc0};
        for (int v = 0; v < 2; v++) begin
            w_ovf[v]     = w_route[v] & ~w_pop[v] & (r_occ[v] == FULL);
            w_push[v]    = w_route[v] & ~w_ovf[v];
            w_unf[v]     = w_pop[v] & ~w_push[v] & (r_occ[v] == '0);
            w_occ_nxt[v] = r_occ[v];
            if (w_push[v] & ~w_pop[v])
                w_occ_nxt[v] = r_occ[v] + OW'(1);
            else if (w_pop[v] & ~w_push[v] & ~w_unf[v])
                w_occ_nxt[v] = r_occ[v] - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state[0] <= RUN;
            r_state[1] <= RUN;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    always_comb begin
        for (int v = 0; v < 2; v++) begin
            w_eff[v]       = {1'b0, r_occ[v]} + {{OW{1'b0}}, w_push[v]};
            w_state_nxt[v] = r_state[v];
            case (r_state[v])
                RUN:    if (w_eff[v] >= HI) w_state_nxt[v] = PAUSED;
                PAUSED: if (w_eff[v] <= LO) w_state_nxt[v] = RUN;
            endcase
        end
    end

    always_comb begin
        pause_vc0 = (r_state[0] == PAUSED);
        pause_vc1 = (r_state[1] == PAUSED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                r_occ[v]  <= '0;
                r_data[v] <= '0;
            end
        end else begin
            r_push <= w_push;
            r_ovf  <= r_ovf | (|w_ovf);
            r_unf  <= r_unf | (|w_unf);
            for (int v = 0; v < 2; v++) begin
                r_occ[v] <= w_occ_nxt[v];
                if (w_push[v])
                    r_data[v] <= data_in;
            end
        end
    end

    assign push_vc0      = r_push[0];
    assign push_vc1      = r_push[1];
    assign data_out_vc0  = r_data[0];
    assign data_out_vc1  = r_data[1];
    assign occ_vc0       = r_occ[0];
    assign occ_vc1       = r_occ[1];
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule
